// File: rtl/servo_ramp_sched_if.sv
// Target handshake and commanded-position bundle between the command path
// and the servo slew-rate scheduler.
interface servo_ramp_sched_if #(
   parameter int POS_W = 8
) ();
   logic             tick;
   logic             tgt_valid;
   logic             tgt_ready;
   logic [POS_W-1:0] tgt_pos;
   logic             abort;
   logic [POS_W-1:0] pos;
   logic             pos_upd;
   logic             busy;
   logic             clamp_err;

   modport master (
      output tick, tgt_valid, tgt_pos, abort,
      input  tgt_ready, pos, pos_upd, busy, clamp_err
   );

   modport slave (
      input  tick, tgt_valid, tgt_pos, abort,
      output tgt_ready, pos, pos_upd, busy, clamp_err
   );
endinterface

// File: rtl/servo_ramp_sched.sv
// Slew-rate scheduler: walks the commanded servo position toward the accepted
// target by at most STEP per update, one update every TICKS_PER_STEP ticks.
module servo_ramp_sched #(
   parameter int POS_W          = 8,
   parameter int STEP           = 4,
   parameter int POS_MIN        = 0,
   parameter int POS_MAX        = 180,
   parameter int POS_RESET      = 90,
   parameter int TICKS_PER_STEP = 1
) (
   input logic               clk,
   input logic               rst_n,
   servo_ramp_sched_if.slave bus
);
   localparam int                TCNT_W      = $clog2(TICKS_PER_STEP + 1);
   localparam logic [POS_W-1:0]  POS_MIN_V   = POS_W'(POS_MIN);
   localparam logic [POS_W-1:0]  POS_MAX_V   = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]  POS_RESET_V = POS_W'(POS_RESET);
   localparam logic [POS_W-1:0]  STEP_V      = POS_W'(STEP);
   localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TICKS_PER_STEP - 1);
   localparam logic [TCNT_W-1:0] TCNT_ONE    = TCNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [POS_W-1:0]    pos_q, pos_d;
   logic [POS_W-1:0]    tgt_q, tgt_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic                upd_q, upd_d;
   logic                busy_q, busy_d;
   logic                clamp_q, clamp_d;

   logic                ready_s;
   logic                accept_s;
   logic [POS_W-1:0]    tgt_clamped_s;
   logic                tgt_clamp_s;
   logic [POS_W:0]      diff_s;
   logic [POS_W:0]      mag_s;
   logic                down_s;
   logic [POS_W-1:0]    step_s;
   logic [POS_W-1:0]    pos_step_s;

   function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v);
      if (int'(v) < POS_MIN) begin
         return POS_MIN_V;
      end else if (int'(v) > POS_MAX) begin
         return POS_MAX_V;
      end else begin
         return v;
      end
   endfunction

   // Handshake and the bounded step toward the current target.
   always_comb begin
      ready_s       = !bus.abort && (state_q != ST_STEP);
      accept_s      = bus.tgt_valid && ready_s;
      tgt_clamped_s = clamp_pos(bus.tgt_pos);
      tgt_clamp_s   = (tgt_clamped_s != bus.tgt_pos);
      // One extra bit keeps the sign of target-pos; its magnitude always fits POS_W.
      diff_s        = {1'b0, tgt_q} - {1'b0, pos_q};
      down_s        = diff_s[POS_W];
      mag_s         = down_s ? ((POS_W+1)'(0) - diff_s) : diff_s;
      step_s        = (mag_s > {1'b0, STEP_V}) ? STEP_V : mag_s[POS_W-1:0];
      pos_step_s    = down_s ? (pos_q - step_s) : (pos_q + step_s);
   end

   // Next-state logic; abort overrides everything including an in-flight step.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      tcnt_d  = tcnt_q;
      upd_d   = 1'b0;
      clamp_d = clamp_q;
      if (bus.abort) begin
         tgt_d   = pos_q;
         tcnt_d  = '0;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  tgt_d   = tgt_clamped_s;
                  clamp_d = tgt_clamp_s;
                  if (tgt_clamped_s != pos_q) begin
                     state_d = ST_RAMP;
                     tcnt_d  = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RAMP: begin
               if (bus.tick) begin
                  if (tcnt_q == TCNT_LAST) begin
                     tcnt_d  = '0;
                     state_d = ST_STEP;
                  end else begin
                     tcnt_d  = tcnt_q + TCNT_ONE;
                  end
               end else begin
                  tcnt_d = tcnt_q;
               end
               // A retarget keeps the prescale count unless it lands on pos.
               if (accept_s) begin
                  tgt_d   = tgt_clamped_s;
                  clamp_d = tgt_clamp_s;
                  if (tgt_clamped_s == pos_q) begin
                     state_d = ST_IDLE;
                     tcnt_d  = '0;
                  end else begin
                     tgt_d = tgt_clamped_s;
                  end
               end else begin
                  tgt_d = tgt_q;
               end
            end
            ST_STEP: begin
               pos_d   = pos_step_s;
               upd_d   = 1'b1;
               state_d = (pos_step_s == tgt_q) ? ST_IDLE : ST_RAMP;
            end
            default: begin
               state_d = ST_IDLE;
               tgt_d   = pos_q;
               tcnt_d  = '0;
            end
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pos_q   <= POS_RESET_V;
         tgt_q   <= POS_RESET_V;
         tcnt_q  <= '0;
         upd_q   <= 1'b0;
         busy_q  <= 1'b0;
         clamp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         tgt_q   <= tgt_d;
         tcnt_q  <= tcnt_d;
         upd_q   <= upd_d;
         busy_q  <= busy_d;
         clamp_q <= clamp_d;
      end
   end

   assign bus.tgt_ready = ready_s;
   assign bus.pos       = pos_q;
   assign bus.pos_upd   = upd_q;
   assign bus.busy      = busy_q;
   assign bus.clamp_err = clamp_q;
endmodule

// File: tb/tb_servo_ramp_sched.sv
// Bench for servo_ramp_sched: two instances (1 and 3 ticks per step) share
// stimulus and are checked every cycle against an event-level model.
module tb_servo_ramp_sched;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick  = 1'b0;
   logic       vld   = 1'b0;
   logic [7:0] tpos  = 8'd0;
   logic       abrt  = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   servo_ramp_sched_if #(.POS_W(8)) bus1 ();
   servo_ramp_sched_if #(.POS_W(8)) bus3 ();

   assign bus1.tick = tick;  assign bus1.tgt_valid = vld;
   assign bus1.tgt_pos = tpos; assign bus1.abort = abrt;
   assign bus3.tick = tick;  assign bus3.tgt_valid = vld;
   assign bus3.tgt_pos = tpos; assign bus3.abort = abrt;

   servo_ramp_sched #(.POS_W(8), .STEP(4), .POS_MIN(0), .POS_MAX(180), .POS_RESET(90),
                      .TICKS_PER_STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   servo_ramp_sched #(.POS_W(8), .STEP(4), .POS_MIN(0), .POS_MAX(180), .POS_RESET(90),
                      .TICKS_PER_STEP(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   // Model: position/target as integers, a tick counter, and the clock edge at
   // which the next scheduled position change becomes visible (-1 = none).
   int TPS_TBL[2] = '{1, 3};
   int m_pos[2]   = '{90, 90};
   int m_tgt[2]   = '{90, 90};
   int m_ticks[2] = '{0, 0};
   int m_due[2]   = '{-1, -1};
   int m_upd[2]   = '{0, 0};
   int m_clamp[2] = '{0, 0};
   int cyc        = 0;
   int q1[$];
   int q3[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_edge(input int i);
      int c;
      int d;
      bit acc;
      m_upd[i] = 0;
      acc = vld && !abrt && (m_due[i] != cyc);
      if (abrt) begin
         m_tgt[i] = m_pos[i]; m_ticks[i] = 0; m_due[i] = -1;
      end else begin
         if (m_due[i] == cyc) begin
            d = m_tgt[i] - m_pos[i];
            if (d > 0) m_pos[i] += (d < 4) ? d : 4;
            else       m_pos[i] -= (-d < 4) ? -d : 4;
            m_upd[i] = 1; m_due[i] = -1;
         end else if (tick && m_pos[i] != m_tgt[i]) begin
            m_ticks[i]++;
            if (m_ticks[i] == TPS_TBL[i]) begin
               m_ticks[i] = 0; m_due[i] = cyc + 1;
            end
         end
         if (acc) begin
            c = int'(tpos);
            if (c > 180) c = 180;
            m_clamp[i] = (c != int'(tpos)) ? 1 : 0;
            m_tgt[i] = c;
            if (c == m_pos[i]) begin
               m_ticks[i] = 0; m_due[i] = -1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_pos[i] = 90; m_tgt[i] = 90; m_ticks[i] = 0;
            m_due[i] = -1; m_upd[i] = 0; m_clamp[i] = 0;
         end
         cyc = 0;
      end else begin
         cyc++;
         model_edge(0);
         model_edge(1);
      end
   end

   // Per-cycle compare, away from the active edge; also logs every pos update.
   initial forever begin
      @(posedge clk);
      #3;
      if (rst_n) begin
         chk("pos_tps1",   int'(bus1.pos),       m_pos[0]);
         chk("upd_tps1",   int'(bus1.pos_upd),   m_upd[0]);
         chk("busy_tps1",  int'(bus1.busy),      (m_pos[0] != m_tgt[0]) ? 1 : 0);
         chk("clamp_tps1", int'(bus1.clamp_err), m_clamp[0]);
         chk("ready_tps1", int'(bus1.tgt_ready), (!abrt && m_due[0] != cyc + 1) ? 1 : 0);
         chk("pos_tps3",   int'(bus3.pos),       m_pos[1]);
         chk("upd_tps3",   int'(bus3.pos_upd),   m_upd[1]);
         chk("busy_tps3",  int'(bus3.busy),      (m_pos[1] != m_tgt[1]) ? 1 : 0);
         chk("clamp_tps3", int'(bus3.clamp_err), m_clamp[1]);
         chk("ready_tps3", int'(bus3.tgt_ready), (!abrt && m_due[1] != cyc + 1) ? 1 : 0);
         if (bus1.pos_upd) q1.push_back(int'(bus1.pos));
         if (bus3.pos_upd) q3.push_back(int'(bus3.pos));
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input int t);
      @(negedge clk); vld = 1'b1; tpos = 8'(t);
      @(negedge clk); vld = 1'b0;
   endtask

   task automatic do_tick();
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((bus1.busy || bus3.busy) && k < budget) begin
         do_tick();
         k++;
      end
      chk("idle_within_budget", int'(bus1.busy || bus3.busy), 0);
   endtask

   initial begin
      int k;
      int n3_at[7];
      // 1: reset state, idle ticks do nothing
      cyc_n(3); #2; rst_n = 1'b1;
      @(posedge clk); #3;
      chk("rst_pos", int'(bus1.pos), 90);
      chk("rst_busy", int'(bus1.busy), 0);
      chk("rst_ready", int'(bus1.tgt_ready), 1);
      chk("rst_upd", int'(bus1.pos_upd), 0);
      q1.delete(); q3.delete();
      repeat (10) do_tick();
      chk("idle_ticks_no_upd", q1.size() + q3.size(), 0);

      // 2: ramp up 90 -> 100
      send(100); q1.delete();
      repeat (3) do_tick();
      chk("up_count", q1.size(), 3);
      chk("up_0", q1[0], 94);
      chk("up_1", q1[1], 98);
      chk("up_2", q1[2], 100);
      chk("up_busy_done", int'(bus1.busy), 0);
      wait_idle(20);

      // 3: out-of-range target clamps to 180, then ramp back down to 80
      send(250);
      chk("clamp_set", int'(bus1.clamp_err), 1);
      wait_idle(100);
      chk("clamp_reach", int'(bus1.pos), 180);
      q1.delete();
      send(80);
      chk("clamp_clear", int'(bus1.clamp_err), 0);
      wait_idle(100);
      chk("down_count", q1.size(), 25);
      chk("down_0", q1[0], 176);
      chk("down_1", q1[1], 172);
      chk("down_last", q1[q1.size() - 1], 80);

      // 4a: retarget mid-ramp to a point just behind the next step
      send(90); wait_idle(20);
      send(120);
      k = 0;
      while (bus1.pos != 8'd98 && k < 10) begin do_tick(); k++; end
      chk("reach_98", int'(bus1.pos), 98);
      send(96); do_tick();
      chk("retarget_pos", int'(bus1.pos), 96);
      chk("retarget_idle", int'(bus1.busy), 0);

      // 4b: abort with a simultaneous offer
      send(90); wait_idle(20);
      send(120); do_tick();
      chk("pre_abort_pos", int'(bus1.pos), 94);
      @(negedge clk); abrt = 1'b1; vld = 1'b1; tpos = 8'd250;
      @(negedge clk); abrt = 1'b0; vld = 1'b0;
      cyc_n(1);
      chk("abort_busy", int'(bus1.busy), 0);
      chk("abort_not_accepted", int'(bus1.clamp_err), 0);
      q1.delete();
      repeat (5) do_tick();
      chk("abort_no_upd", q1.size(), 0);
      chk("abort_pos", int'(bus1.pos), 94);

      // 5: prescale of three ticks per update
      send(90); wait_idle(20);
      q3.delete();
      send(98);
      for (int t = 1; t <= 6; t++) begin
         do_tick();
         n3_at[t] = q3.size();
      end
      chk("tps3_after2", n3_at[2], 0);
      chk("tps3_after3", n3_at[3], 1);
      chk("tps3_after5", n3_at[5], 1);
      chk("tps3_after6", n3_at[6], 2);
      chk("tps3_val0", q3[0], 94);
      chk("tps3_val1", q3[1], 98);
      q1.delete(); q3.delete();
      send(98); cyc_n(2);
      chk("same_tgt_busy", int'(bus3.busy), 0);
      repeat (3) do_tick();
      chk("same_tgt_no_upd", q1.size() + q3.size(), 0);

      // 6: tick during the step cycle is not counted
      send(110); q3.delete();
      @(negedge clk); tick = 1'b1;
      repeat (4) @(negedge clk);
      tick = 1'b0;
      cyc_n(3);
      chk("step_tick_count", q3.size(), 1);
      chk("step_tick_pos", int'(bus3.pos), 102);
      repeat (2) do_tick();
      chk("step_tick_ignored", int'(bus3.pos), 102);

      // 6: asynchronous reset between edges while ramping
      send(130); do_tick();
      @(negedge clk); #2; rst_n = 1'b0; #1;
      chk("arst_pos1", int'(bus1.pos), 90);
      chk("arst_pos3", int'(bus3.pos), 90);
      chk("arst_busy", int'(bus1.busy || bus3.busy), 0);
      chk("arst_upd", int'(bus1.pos_upd || bus3.pos_upd), 0);
      @(negedge clk); #2; rst_n = 1'b1;
      q1.delete(); q3.delete();
      cyc_n(3);
      repeat (3) do_tick();
      chk("arst_exit_no_upd", q1.size() + q3.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
